alien_hit_detector: RTL and testbench
=====================================

Name: alien_hit_detector

Overview:
- Sits directly downstream of the cannon laser stage. Consumes laser_active/laser_x/laser_y and produces the hit_alien signal that the laser stage samples on the next vsync rising edge.
- Owns the alien-alive bitmap for the invader grid. Once per frame it scans the grid cell by cell and detects a laser/alien overlap.
- On a hit it kills exactly one alien, updates the score and alive count, and flags wave clear.

Parameters:
- ALIEN_ROWS, 5, rows in alien grid (max 8).
- ALIEN_COLS, 11, columns in alien grid (max 16).
- CELL_W, 32, horizontal pitch between alien origins, pixels.
- CELL_H, 32, vertical pitch between alien origins, pixels.
- ALIEN_W, 24, alien hitbox width, pixels.
- ALIEN_H, 16, alien hitbox height, pixels.
- LASER_W, 4, laser hitbox width (matches laser stage 1*SCALING).
- LASER_H, 16, laser hitbox height (matches laser stage 4*SCALING).
- POINTS, 10, score added per kill.

Ports:
- clock  in  1  system/pixel clock
- reset_n  in  1  reset, asynchronous, active-low
- vsync  in  1  frame sync from video timing, asynchronous to scan logic
- grid_x  in  10  x of top-left alien origin
- grid_y  in  10  y of top-left alien origin
- laser_active  in  1  laser in flight
- laser_x  in  10  laser top-left x
- laser_y  in  10  laser top-left y
- wave_reset  in  1  sync pulse: revive all aliens
- score_clear  in  1  sync pulse: zero score
- hit_alien  out  1  level; high from hit detection until next scan start
- hit_row  out  3  row of last killed alien
- hit_col  out  4  column of last killed alien
- alive_mask  out  ALIEN_ROWS*ALIEN_COLS  bit (r*ALIEN_COLS+c) = alien alive
- alive_count  out  7  number of live aliens
- all_dead  out  1  alive_count==0
- score  out  16  accumulated score, saturating
- busy  out  1  scan in progress

Behaviour:
Reset:
- alive_mask all ones; alive_count = ALIEN_ROWS*ALIEN_COLS.
- hit_alien, hit_row, hit_col, score, busy and all_dead are 0.
- FSM in IDLE.

vsync handling:
- vsync passes through a 2-flop synchronizer, then a rising-edge detect. The cycle the edge is detected is S.

FSM states: IDLE, CAPTURE, SCAN, UPDATE.
- IDLE -> CAPTURE at S.
- CAPTURE (1 cycle):
  - Register grid_x, grid_y, laser_x, laser_y, laser_active.
  - Clear hit_alien.
  - If laser_active=0, go to IDLE. Otherwise go to SCAN with row=ALIEN_ROWS-1, col=0.
- SCAN (1 cell/cycle), order bottom row first, columns ascending within a row:
  - If the cell is alive and overlaps the laser, go to UPDATE.
  - Else advance. After row 0, col ALIEN_COLS-1, go to IDLE with no hit.
  - busy=1 in CAPTURE, SCAN and UPDATE.
- UPDATE (1 cycle):
  - Clear the alive bit.
  - alive_count -= 1.
  - hit_alien <= 1; hit_row/hit_col <= cell.
  - score <= min(score+POINTS, 16'hFFFF).
  - Go to IDLE.
- At most one kill per frame. Worst-case latency from S is 2 + ALIEN_ROWS*ALIEN_COLS cycles, which must be far below one frame.

Overlap test (all arithmetic 11-bit unsigned, no wrap):
- ax = grid_x + col*CELL_W; ay = grid_y + row*CELL_H.
- Hit iff lx < ax+ALIEN_W, ax < lx+LASER_W, ly < ay+ALIEN_H and ay < ly+LASER_H.
- Edges are exclusive: touching boxes do not hit.

Outputs and boundary cases:
- hit_alien is held stable through the remainder of the frame, so the laser stage samples it at the next vsync edge. It is cleared in CAPTURE, at least 2 clocks after that edge.
- all_dead is combinational from alive_count==0.
- Dead aliens are never hit; the laser passes through empty cells.
- wave_reset (highest priority, any state):
  - alive_mask all ones; alive_count full.
  - hit_alien 0; FSM to IDLE, aborting any scan.
  - score unchanged.
- score_clear: score <= 0 next cycle. If it coincides with an UPDATE, clear wins.
- A vsync edge detected while busy is ignored (no re-trigger).
- reset_n asserted mid-scan returns immediately to the reset values.

Test Plan:
- Reset, then vsync with laser_active=0 -> hit_alien=0, alive_count=55, score=0, busy drops 2 cycles after S.
- grid=(100,100), laser=(108,200) active, vsync:
  - Scan covers row 3 first (ay=196), col 0 (ax=100). Overlap.
  - Expect hit_alien=1, hit_row=3, hit_col=0, alive bit 33 cleared, alive_count=54, score=10.
  - hit_alien stays high until the next CAPTURE.
- Same laser on the following frame:
  - Row 3 col 0 is dead, so the bit-33 cell is skipped.
  - Next overlapping live cell is row 2 col 0 only if within reach; with laser_y=200 there is none.
  - Expect hit_alien=0.
- Edge-touching case: laser_x = ax+ALIEN_W (=124), y overlapping -> no hit. laser_x=123 -> hit.
- Kill all 55 aliens over 55 frames -> all_dead=1, score=550. Then wave_reset -> alive_count=55, all_dead=0, score=550.
- Assert wave_reset during SCAN and reset_n during SCAN -> scan aborted, no kill recorded, outputs at the defined values. Preload score near 16'hFFFF and hit -> score saturates at 16'hFFFF.

Source files
------------

// File: rtl/alien_hit_detector.sv
// Alien-grid hit detector: keeps the alive bitmap, scans one cell per clock after
// each vsync rising edge and kills the first live alien overlapping the laser.
module alien_hit_detector #(
  parameter int ALIEN_ROWS = 5,
  parameter int ALIEN_COLS = 11,
  parameter int CELL_W     = 32,
  parameter int CELL_H     = 32,
  parameter int ALIEN_W    = 24,
  parameter int ALIEN_H    = 16,
  parameter int LASER_W    = 4,
  parameter int LASER_H    = 16,
  parameter int POINTS     = 10
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             vsync,
  input  logic [9:0]                       grid_x,
  input  logic [9:0]                       grid_y,
  input  logic                             laser_active,
  input  logic [9:0]                       laser_x,
  input  logic [9:0]                       laser_y,
  input  logic                             wave_reset,
  input  logic                             score_clear,
  output logic                             hit_alien,
  output logic [2:0]                       hit_row,
  output logic [3:0]                       hit_col,
  output logic [ALIEN_ROWS*ALIEN_COLS-1:0] alive_mask,
  output logic [6:0]                       alive_count,
  output logic                             all_dead,
  output logic [15:0]                      score,
  output logic                             busy
);

  localparam int N = ALIEN_ROWS * ALIEN_COLS;
  localparam logic [N-1:0] ALL_ALIVE = {N{1'b1}};
  localparam logic [N-1:0] ONE_BIT = {{(N-1){1'b0}}, 1'b1};
  localparam logic [6:0] FULL_COUNT = 7'(N);
  localparam logic [2:0] LAST_ROW = 3'(ALIEN_ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(ALIEN_COLS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, SCAN = 2'd2, UPDATE = 2'd3} state_e;

  state_e        state_q, state_d;
  logic          vs_meta_q, vs_sync_q, vs_prev_q;
  logic          vs_rise;
  logic [2:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [9:0]    gx_q, gx_d, gy_q, gy_d, lx_q, lx_d, ly_q, ly_d;
  logic [N-1:0]  alive_q, alive_d;
  logic [6:0]    count_q, count_d;
  logic          hit_q, hit_d;
  logic [2:0]    hit_row_q, hit_row_d;
  logic [3:0]    hit_col_q, hit_col_d;
  logic [15:0]   score_q, score_d;
  logic [10:0]   ax, ay, lx11, ly11;
  logic [6:0]    cell_idx;
  logic [N-1:0]  cell_bit;
  logic          overlap, cell_hit, last_cell;
  logic [16:0]   score_sum;

  assign vs_rise   = vs_sync_q & ~vs_prev_q;
  assign ax        = {1'b0, gx_q} + 11'(col_q) * 11'(CELL_W);
  assign ay        = {1'b0, gy_q} + 11'(row_q) * 11'(CELL_H);
  assign lx11      = {1'b0, lx_q};
  assign ly11      = {1'b0, ly_q};
  // Strict compares make edge-touching boxes miss.
  assign overlap   = (lx11 < ax + 11'(ALIEN_W)) && (ax < lx11 + 11'(LASER_W)) &&
                     (ly11 < ay + 11'(ALIEN_H)) && (ay < ly11 + 11'(LASER_H));
  assign cell_idx  = 7'(row_q) * 7'(ALIEN_COLS) + 7'(col_q);
  assign cell_bit  = ONE_BIT << cell_idx;
  assign cell_hit  = (|(alive_q & cell_bit)) && overlap;
  assign last_cell = (row_q == 3'd0) && (col_q == LAST_COL);
  assign score_sum = {1'b0, score_q} + 17'(POINTS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wave_reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = vs_rise ? CAPTURE : IDLE;
        CAPTURE: state_d = laser_active ? SCAN : IDLE;
        SCAN: begin
          if (cell_hit)       state_d = UPDATE;
          else if (last_cell) state_d = IDLE;
          else                state_d = SCAN;
        end
        UPDATE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    lx_d      = lx_q;
    ly_d      = ly_q;
    alive_d   = alive_q;
    count_d   = count_q;
    hit_d     = hit_q;
    hit_row_d = hit_row_q;
    hit_col_d = hit_col_q;
    score_d   = score_q;
    if (wave_reset) begin
      alive_d = ALL_ALIVE;
      count_d = FULL_COUNT;
      hit_d   = 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          gx_d  = grid_x;
          gy_d  = grid_y;
          lx_d  = laser_x;
          ly_d  = laser_y;
          hit_d = 1'b0;
          row_d = LAST_ROW;
          col_d = 4'd0;
        end
        SCAN: begin
          if (!cell_hit) begin
            if (col_q == LAST_COL) begin
              col_d = 4'd0;
              row_d = row_q - 3'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
        UPDATE: begin
          alive_d   = alive_q & ~cell_bit;
          count_d   = count_q - 7'd1;
          hit_d     = 1'b1;
          hit_row_d = row_q;
          hit_col_d = col_q;
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
        default: begin
          row_d = row_q;
        end
      endcase
    end
    if (score_clear) begin
      score_d = 16'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q     <= 3'd0;
      col_q     <= 4'd0;
      gx_q      <= 10'd0;
      gy_q      <= 10'd0;
      lx_q      <= 10'd0;
      ly_q      <= 10'd0;
      alive_q   <= ALL_ALIVE;
      count_q   <= FULL_COUNT;
      hit_q     <= 1'b0;
      hit_row_q <= 3'd0;
      hit_col_q <= 4'd0;
      score_q   <= 16'd0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      alive_q   <= alive_d;
      count_q   <= count_d;
      hit_q     <= hit_d;
      hit_row_q <= hit_row_d;
      hit_col_q <= hit_col_d;
      score_q   <= score_d;
    end
  end

  assign hit_alien   = hit_q;
  assign hit_row     = hit_row_q;
  assign hit_col     = hit_col_q;
  assign alive_mask  = alive_q;
  assign alive_count = count_q;
  assign all_dead    = (count_q == 7'd0);
  assign score       = score_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alien_hit_detector.sv
// Randomized frame-level bench for alien_hit_detector against a grid/score model;
// a second instance with large POINTS exercises score saturation.
module tb_alien_hit_detector;
  localparam int R = 5;
  localparam int C = 11;
  localparam int N = R * C;
  localparam int PTS2 = 20000;

  logic clock = 1'b0, reset_n = 1'b0, vsync = 1'b0;
  logic [9:0] grid_x = 10'd0, grid_y = 10'd0, laser_x = 10'd0, laser_y = 10'd0;
  logic laser_active = 1'b0, wave_reset = 1'b0, score_clear = 1'b0;
  logic hit_alien, all_dead, busy, hit_alien2, all_dead2, busy2;
  logic [2:0] hit_row, hit_row2;
  logic [3:0] hit_col, hit_col2;
  logic [N-1:0] alive_mask, alive_mask2;
  logic [6:0] alive_count, alive_count2;
  logic [15:0] score, score2;

  alien_hit_detector dut (
    .clock(clock), .reset_n(reset_n), .vsync(vsync), .grid_x(grid_x), .grid_y(grid_y),
    .laser_active(laser_active), .laser_x(laser_x), .laser_y(laser_y),
    .wave_reset(wave_reset), .score_clear(score_clear), .hit_alien(hit_alien),
    .hit_row(hit_row), .hit_col(hit_col), .alive_mask(alive_mask),
    .alive_count(alive_count), .all_dead(all_dead), .score(score), .busy(busy));

  alien_hit_detector #(.POINTS(PTS2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .vsync(vsync), .grid_x(grid_x), .grid_y(grid_y),
    .laser_active(laser_active), .laser_x(laser_x), .laser_y(laser_y),
    .wave_reset(wave_reset), .score_clear(score_clear), .hit_alien(hit_alien2),
    .hit_row(hit_row2), .hit_col(hit_col2), .alive_mask(alive_mask2),
    .alive_count(alive_count2), .all_dead(all_dead2), .score(score2), .busy(busy2));

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  bit m_alive [R][C];
  int m_count, m_score, m_score2, m_hit, m_row, m_col;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_mask();
    logic [63:0] m = 64'd0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[r*C+c] = m_alive[r][c];
    return m;
  endfunction

  function automatic void model_revive();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m_alive[r][c] = 1'b1;
    m_count = N;
    m_hit = 0;
  endfunction

  // Scan order: bottom row first, columns ascending; returns scan index or -1.
  function automatic int model_find(input int gx, gy, lx, ly, output int hr, output int hc);
    hr = 0; hc = 0;
    for (int r = R - 1; r >= 0; r--)
      for (int c = 0; c < C; c++) begin
        int ax = gx + c * 32;
        int ay = gy + r * 32;
        if (m_alive[r][c] && lx < ax + 24 && ax < lx + 4 && ly < ay + 16 && ay < ly + 16) begin
          hr = r; hc = c;
          return (R - 1 - r) * C + c;
        end
      end
    return -1;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ":hit_alien"}, hit_alien, m_hit);
    check_eq({tag, ":hit_row"}, hit_row, m_row);
    check_eq({tag, ":hit_col"}, hit_col, m_col);
    check_eq({tag, ":alive_mask"}, alive_mask, exp_mask());
    check_eq({tag, ":alive_count"}, alive_count, m_count);
    check_eq({tag, ":all_dead"}, all_dead, (m_count == 0));
    check_eq({tag, ":score"}, score, m_score);
    check_eq({tag, ":score_sat"}, score2, m_score2);
    check_eq({tag, ":busy_idle"}, busy, 0);
  endtask

  // abort_kind: 0 none, 1 wave_reset, 2 reset_n; applied abort_at cycles after vsync rises.
  task automatic run_frame(input string tag, input int gx, gy, la, lx, ly, abort_kind, abort_at);
    int busy_cnt = 0, exp_busy, k, hr, hc;
    bit seen = 0, hold_ok = 1;
    @(negedge clock);
    grid_x = gx[9:0]; grid_y = gy[9:0]; laser_x = lx[9:0]; laser_y = ly[9:0];
    laser_active = la[0];
    vsync = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock); #1;
      if (abort_kind != 0 && i == abort_at) begin
        check_eq({tag, ":busy_before_abort"}, busy, 1);
        vsync = 1'b0;
        if (abort_kind == 1) wave_reset = 1'b1;
        else reset_n = 1'b0;
      end else if (abort_kind != 0 && i == abort_at + 1) begin
        wave_reset = 1'b0;
        reset_n = 1'b1;
      end
      if (busy) begin busy_cnt++; seen = 1; end
      if (!seen && hit_alien !== m_hit[0]) hold_ok = 0;
    end
    vsync = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    k = -1;
    if (abort_kind == 1) begin
      model_revive();
    end else if (abort_kind == 2) begin
      model_revive();
      m_row = 0; m_col = 0; m_score = 0; m_score2 = 0;
    end else begin
      m_hit = 0;
      if (la != 0) begin
        k = model_find(gx, gy, lx, ly, hr, hc);
        if (k >= 0) begin
          m_alive[hr][hc] = 1'b0;
          m_count--;
          m_hit = 1; m_row = hr; m_col = hc;
          m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
          m_score2 = (m_score2 + PTS2 > 65535) ? 65535 : m_score2 + PTS2;
        end
      end
      exp_busy = (la == 0) ? 1 : ((k >= 0) ? k + 3 : N + 1);
      check_eq({tag, ":busy_cycles"}, busy_cnt, exp_busy);
      check_eq({tag, ":hit_hold"}, hold_ok, 1);
    end
    check_state(tag);
  endtask

  task automatic pulse_wave_reset();
    @(negedge clock); wave_reset = 1'b1;
    @(negedge clock); wave_reset = 1'b0;
    model_revive();
    #1 check_state("wave_reset");
  endtask

  task automatic pulse_score_clear();
    @(negedge clock); score_clear = 1'b1;
    @(negedge clock); score_clear = 1'b0;
    m_score = 0; m_score2 = 0;
    #1 check_state("score_clear");
  endtask

  initial begin
    int gx, gy, lx, ly, t;
    model_revive();
    m_row = 0; m_col = 0; m_score = 0; m_score2 = 0;
    repeat (3) @(posedge clock);
    #1 check_state("reset");
    @(negedge clock); reset_n = 1'b1;

    run_frame("laser_off", 100, 100, 0, 108, 200, 0, 0);
    run_frame("first_hit", 100, 100, 1, 108, 200, 0, 0);
    run_frame("dead_cell", 100, 100, 1, 108, 200, 0, 0);
    run_frame("right_touch", 100, 100, 1, 156, 200, 0, 0);
    run_frame("right_in", 100, 100, 1, 155, 200, 0, 0);
    run_frame("left_touch", 100, 100, 1, 160, 200, 0, 0);
    run_frame("left_in", 100, 100, 1, 161, 200, 0, 0);
    run_frame("vert_touch", 100, 100, 1, 200, 212, 0, 0);
    run_frame("vert_in", 100, 100, 1, 200, 211, 0, 0);

    for (int i = 0; i < 30; i++) begin
      gx = $urandom_range(0, 600);
      gy = $urandom_range(0, 500);
      t = $urandom_range(0, 370); lx = gx + t - 10; if (lx < 0) lx = 0;
      t = $urandom_range(0, 170); ly = gy + t - 10; if (ly < 0) ly = 0;
      run_frame("random", gx, gy, ($urandom_range(0, 4) != 0) ? 1 : 0, lx, ly, 0, 0);
      if ($urandom_range(0, 5) == 0) pulse_score_clear();
    end

    pulse_wave_reset();
    pulse_score_clear();
    for (int r = R - 1; r >= 0; r--)
      for (int c = 0; c < C; c++)
        run_frame("kill_all", 100, 100, 1, 110 + c * 32, 100 + r * 32, 0, 0);
    check_eq("final_score", score, 550);
    check_eq("final_all_dead", all_dead, 1);
    run_frame("empty_grid", 100, 100, 1, 110, 228, 0, 0);
    pulse_wave_reset();

    run_frame("abort_wave", 100, 100, 1, 430, 100, 1, 10);
    run_frame("abort_reset", 100, 100, 1, 430, 100, 2, 10);
    run_frame("after_abort", 100, 100, 1, 430, 100, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
